// File: rtl/pipe_trace_buffer_pkg.sv
// Shared widths and trace FSM state encodings for pipe_trace_buffer.
package pipe_trace_buffer_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned IWIDTH   = 32;

  // TR_CAPTURE is used by the plain build; ARMED/POST/FROZEN by the trigger build.
  typedef enum logic [2:0] {
    TR_IDLE    = 3'd0,
    TR_CAPTURE = 3'd1,
    TR_ARMED   = 3'd2,
    TR_POST    = 3'd3,
    TR_FROZEN  = 3'd4
  } tr_state_e;

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x WIDTH array, one synchronous write port and one
// synchronous read port. A same-address read and write returns the old word.
module pipe_trace_buffer_trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     d_clk,
  input  logic                     d_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port; the array itself is not reset.
  always_ff @(posedge d_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port; holds its last value when no read is issued.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Retire-trace capture buffer: circular store of {pc, instr, wb_data} with a
// 1-cycle-latency pop port, wrap/stop full policy and sticky overflow flag.
// Optional PC-match trigger/freeze enabled by defining TRACE_TRIGGER_EN.
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int unsigned PC_W  = PC_WIDTH,
  parameter int unsigned IW    = IWIDTH,
  parameter int unsigned DW    = DWIDTH,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WRAP  = 1,
  parameter int unsigned POST  = 4
) (
  input  logic                       d_clk,
  input  logic                       d_rst,
  input  logic                       d_i_ce,
  input  logic                       i_valid,
  input  logic [PC_W-1:0]            i_pc,
  input  logic [IW-1:0]              i_instr,
  input  logic [DW-1:0]              i_wb_data,
  input  logic                       i_rd_req,
  output logic                       o_rd_valid,
  output logic [PC_W-1:0]            o_rd_pc,
  output logic [IW-1:0]              o_rd_instr,
  output logic [DW-1:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow
`ifdef TRACE_TRIGGER_EN
  ,
  input  logic [PC_W-1:0]            i_trig_pc,
  output logic                       o_frozen
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned EW    = PC_W + IW + DW;
  localparam bit          WrapEn = (WRAP != 0);

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_trace_buffer: DEPTH must be a power of 2 and >= 2");
  end
  if (POST < 1 || POST >= DEPTH) begin : g_bad_post
    $error("pipe_trace_buffer: POST must be in 1..DEPTH-1");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_rd_valid;
  tr_state_e        r_state;

  logic             w_empty;
  logic             w_full;
  logic             w_capture_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_lost;
  logic             w_wr;
  logic             w_rd_adv;
  logic [EW-1:0]    w_rdata;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == (PTR_W + 1)'(DEPTH));
  // Never false in the plain build: only the trigger build reaches TR_FROZEN.
  assign w_capture_ok = (r_state != TR_FROZEN);
  assign w_push       = d_i_ce & i_valid & w_capture_ok;
  assign w_pop        = i_rd_req & ~w_empty;
  // A push into a full buffer with no simultaneous pop loses an entry.
  assign w_lost       = w_push & w_full & ~w_pop;
  assign w_wr         = w_push & (~w_full | w_pop | WrapEn);
  // In wrap mode the oldest entry is discarded by advancing the read pointer.
  assign w_rd_adv     = w_pop | (w_lost & WrapEn);

  pipe_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_trace_ram (
    .d_clk   (d_clk),
    .d_rst   (d_rst),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_pc, i_instr, i_wb_data}),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy, sticky overflow and pop-valid pulse.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd_adv) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
      end
      r_rd_valid <= w_pop;
    end
  end

`ifdef TRACE_TRIGGER_EN
  logic [PTR_W-1:0] r_post_cnt;

  // Trigger FSM: arm, count POST entries after the match, then freeze.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      r_state    <= TR_IDLE;
      r_post_cnt <= '0;
    end else begin
      unique case (r_state)
        TR_IDLE, TR_ARMED: begin
          if (w_push && (i_pc == i_trig_pc)) begin
            r_state    <= TR_POST;
            r_post_cnt <= PTR_W'(POST);
          end else if (d_i_ce) begin
            r_state <= TR_ARMED;
          end
        end
        TR_POST: begin
          if (w_push) begin
            if (r_post_cnt == PTR_W'(1)) begin
              r_state <= TR_FROZEN;
            end
            r_post_cnt <= r_post_cnt - 1'b1;
          end
        end
        TR_FROZEN: r_state <= TR_FROZEN;
        default:   r_state <= TR_IDLE;
      endcase
    end
  end

  assign o_frozen = (r_state == TR_FROZEN);
`else
  // Capture FSM: tracks whether capture is enabled.
  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      r_state <= TR_IDLE;
    end else begin
      r_state <= d_i_ce ? TR_CAPTURE : TR_IDLE;
    end
  end
`endif

  assign o_rd_valid = r_rd_valid;
  assign o_rd_pc    = w_rdata[EW-1 -: PC_W];
  assign o_rd_instr = w_rdata[IW+DW-1 -: IW];
  assign o_rd_data  = w_rdata[DW-1:0];
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: one DEPTH=16 wrap instance plus two
// DEPTH=4 instances (wrap and stop) sharing the same stimulus.
module tb_pipe_trace_buffer;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic        d_i_ce;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic [31:0] i_wb_data;
  logic        i_rd_req;
  logic [31:0] i_trig_pc;

  logic        a_rd_valid, w_rd_valid, s_rd_valid;
  logic [31:0] a_rd_pc, w_rd_pc, s_rd_pc;
  logic [31:0] a_rd_instr, w_rd_instr, s_rd_instr;
  logic [31:0] a_rd_data, w_rd_data, s_rd_data;
  logic [4:0]  a_count;
  logic [2:0]  w_count, s_count;
  logic        a_empty, w_empty, s_empty;
  logic        a_full, w_full, s_full;
  logic        a_overflow, w_overflow, s_overflow;
  logic        a_frozen, w_frozen, s_frozen;

  int n_vec = 0;
  int n_err = 0;

  always #5 d_clk = ~d_clk;

  pipe_trace_buffer #(.DEPTH(16), .WRAP(1), .POST(2)) u_a (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .i_valid(i_valid), .i_pc(i_pc),
    .i_instr(i_instr), .i_wb_data(i_wb_data), .i_rd_req(i_rd_req), .o_rd_valid(a_rd_valid),
    .o_rd_pc(a_rd_pc), .o_rd_instr(a_rd_instr), .o_rd_data(a_rd_data), .o_count(a_count),
    .o_empty(a_empty), .o_full(a_full), .o_overflow(a_overflow)
`ifdef TRACE_TRIGGER_EN
    , .i_trig_pc(i_trig_pc), .o_frozen(a_frozen)
`endif
  );

  pipe_trace_buffer #(.DEPTH(4), .WRAP(1), .POST(2)) u_w (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .i_valid(i_valid), .i_pc(i_pc),
    .i_instr(i_instr), .i_wb_data(i_wb_data), .i_rd_req(i_rd_req), .o_rd_valid(w_rd_valid),
    .o_rd_pc(w_rd_pc), .o_rd_instr(w_rd_instr), .o_rd_data(w_rd_data), .o_count(w_count),
    .o_empty(w_empty), .o_full(w_full), .o_overflow(w_overflow)
`ifdef TRACE_TRIGGER_EN
    , .i_trig_pc(i_trig_pc), .o_frozen(w_frozen)
`endif
  );

  pipe_trace_buffer #(.DEPTH(4), .WRAP(0), .POST(2)) u_s (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_ce(d_i_ce), .i_valid(i_valid), .i_pc(i_pc),
    .i_instr(i_instr), .i_wb_data(i_wb_data), .i_rd_req(i_rd_req), .o_rd_valid(s_rd_valid),
    .o_rd_pc(s_rd_pc), .o_rd_instr(s_rd_instr), .o_rd_data(s_rd_data), .o_count(s_count),
    .o_empty(s_empty), .o_full(s_full), .o_overflow(s_overflow)
`ifdef TRACE_TRIGGER_EN
    , .i_trig_pc(i_trig_pc), .o_frozen(s_frozen)
`endif
  );

`ifndef TRACE_TRIGGER_EN
  assign a_frozen = 1'b0;
  assign w_frozen = 1'b0;
  assign s_frozen = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  task automatic set_entry(input logic [31:0] pc);
    i_pc      = pc;
    i_instr   = 32'h2008_0005 + pc / 4;
    i_wb_data = 32'd5 + pc / 4;
  endtask

  task automatic push(input logic [31:0] pc);
    set_entry(pc);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pop();
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
  endtask

  task automatic do_reset();
    d_rst    = 1'b1;
    d_i_ce   = 1'b0;
    i_valid  = 1'b0;
    i_rd_req = 1'b0;
    tick();
    tick();
    d_rst  = 1'b0;
    d_i_ce = 1'b1;
  endtask

  initial begin
    d_rst     = 1'b1;
    d_i_ce    = 1'b0;
    i_valid   = 1'b0;
    i_rd_req  = 1'b0;
    i_pc      = '0;
    i_instr   = '0;
    i_wb_data = '0;
    i_trig_pc = 32'hFFFF_FFF0;

    // 1. Reset state, capture enabled with no pushes.
    do_reset();
    tick();
    check_eq("t1 empty", 64'(a_empty), 64'd1);
    check_eq("t1 count", 64'(a_count), 64'd0);
    check_eq("t1 rd_valid", 64'(a_rd_valid), 64'd0);
    check_eq("t1 overflow", 64'(a_overflow), 64'd0);
    check_eq("t1 rd_pc", 64'(a_rd_pc), 64'd0);
    check_eq("t1 frozen", 64'(a_frozen), 64'd0);

    // 2. In-order drain with 1-cycle pop latency.
    push(32'd0);
    push(32'd4);
    push(32'd8);
    check_eq("t2 count", 64'(a_count), 64'd3);
    for (int k = 0; k < 3; k++) begin
      pop();
      check_eq("t2 rd_valid", 64'(a_rd_valid), 64'd1);
      check_eq("t2 rd_pc", 64'(a_rd_pc), 64'(4 * k));
      check_eq("t2 rd_instr", 64'(a_rd_instr), 64'(32'h2008_0005 + k));
      check_eq("t2 rd_data", 64'(a_rd_data), 64'(5 + k));
    end
    check_eq("t2 empty", 64'(a_empty), 64'd1);
    tick();
    check_eq("t2 valid pulse", 64'(a_rd_valid), 64'd0);
    pop();
    check_eq("t2 empty pop valid", 64'(a_rd_valid), 64'd0);
    check_eq("t2 empty pop hold", 64'(a_rd_pc), 64'd8);
    check_eq("t2 empty pop count", 64'(a_count), 64'd0);

    // 3. Overfill DEPTH=4: wrap keeps newest, stop keeps oldest.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push(32'(4 * k));
    end
    check_eq("t3 wrap count", 64'(w_count), 64'd4);
    check_eq("t3 wrap full", 64'(w_full), 64'd1);
    check_eq("t3 wrap overflow", 64'(w_overflow), 64'd1);
    check_eq("t3 stop count", 64'(s_count), 64'd4);
    check_eq("t3 stop overflow", 64'(s_overflow), 64'd1);
    check_eq("t3 d16 overflow", 64'(a_overflow), 64'd0);
    for (int k = 0; k < 4; k++) begin
      pop();
      check_eq("t3 wrap rd_pc", 64'(w_rd_pc), 64'(8 + 4 * k));
      check_eq("t3 stop rd_pc", 64'(s_rd_pc), 64'(4 * k));
    end
    check_eq("t3 wrap empty", 64'(w_empty), 64'd1);
    check_eq("t3 overflow sticky", 64'(w_overflow), 64'd1);

    // 4. Full buffer, push and pop in the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(32'(4 * k));
    end
    check_eq("t4 full", 64'(w_full), 64'd1);
    set_entry(32'd16);
    i_valid  = 1'b1;
    i_rd_req = 1'b1;
    tick();
    i_valid  = 1'b0;
    i_rd_req = 1'b0;
    check_eq("t4 wrap count", 64'(w_count), 64'd4);
    check_eq("t4 wrap overflow", 64'(w_overflow), 64'd0);
    check_eq("t4 wrap rd_valid", 64'(w_rd_valid), 64'd1);
    check_eq("t4 wrap rd_pc", 64'(w_rd_pc), 64'd0);
    check_eq("t4 stop count", 64'(s_count), 64'd4);
    check_eq("t4 stop overflow", 64'(s_overflow), 64'd0);
    check_eq("t4 stop rd_pc", 64'(s_rd_pc), 64'd0);
    for (int k = 0; k < 4; k++) begin
      pop();
      check_eq("t4 wrap drain", 64'(w_rd_pc), 64'(4 + 4 * k));
      check_eq("t4 stop drain", 64'(s_rd_pc), 64'(4 + 4 * k));
    end

`ifdef TRACE_TRIGGER_EN
    // 5. Trigger at PC 16 with POST=2 freezes after PC 24.
    do_reset();
    i_trig_pc = 32'd16;
    for (int k = 0; k < 11; k++) begin
      push(32'(4 * k));
    end
    check_eq("t5 frozen", 64'(a_frozen), 64'd1);
    check_eq("t5 count", 64'(a_count), 64'd7);
    for (int k = 0; k < 7; k++) begin
      pop();
      check_eq("t5 rd_pc", 64'(a_rd_pc), 64'(4 * k));
    end
    check_eq("t5 empty", 64'(a_empty), 64'd1);
    push(32'd44);
    check_eq("t5 frozen drop", 64'(a_count), 64'd0);
    i_trig_pc = 32'hFFFF_FFF0;
`endif

    // 6. Reset mid-drain discards contents and dominates a pop.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(32'(4 * k));
    end
    pop();
    check_eq("t6 pre rd_pc", 64'(a_rd_pc), 64'd0);
    check_eq("t6 pre count", 64'(a_count), 64'd3);
    d_rst    = 1'b1;
    i_rd_req = 1'b1;
    tick();
    d_rst    = 1'b0;
    i_rd_req = 1'b0;
    check_eq("t6 count", 64'(a_count), 64'd0);
    check_eq("t6 empty", 64'(a_empty), 64'd1);
    check_eq("t6 rd_valid", 64'(a_rd_valid), 64'd0);
    check_eq("t6 rd_pc", 64'(a_rd_pc), 64'd0);
    check_eq("t6 frozen", 64'(a_frozen), 64'd0);
    check_eq("t6 overflow", 64'(w_overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
